// File: rtl/imagem_pkg.sv
// imagem_pkg: shared widths and controller state encoding for the image stream reader
package imagem_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;
  localparam int LEN_W = 19;
  localparam int FIFO_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/imagem_stream_reader_if.sv
// imagem_stream_reader_if: Avalon-MM read port plus Avalon-ST source bundled for the reader
interface imagem_stream_reader_if #(
  parameter int AW = imagem_pkg::ADDR_W,
  parameter int DW = imagem_pkg::DATA_W
);
  logic [AW-1:0] avm_address;
  logic avm_read;
  logic avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic avm_readdatavalid;
  logic [DW-1:0] src_data;
  logic src_valid;
  logic src_ready;
  logic src_sop;
  logic src_eop;
  modport master (
    output avm_address, avm_read, src_data, src_valid, src_sop, src_eop,
    input avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready
  );
  modport slave (
    input avm_address, avm_read, src_data, src_valid, src_sop, src_eop,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready
  );
endinterface

// File: rtl/imagem_sync_fifo.sv
// imagem_sync_fifo: show-ahead synchronous FIFO with occupancy count and async reset
module imagem_sync_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [W-1:0] wdata,
  input  logic pop,
  output logic [W-1:0] rdata,
  output logic empty,
  output logic [AW:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/imagem_stream_reader.sv
// imagem_stream_reader: credit-limited Avalon-MM read master streaming a RAM block as an Avalon-ST packet
module imagem_stream_reader #(
  parameter int ADDR_W = imagem_pkg::ADDR_W,
  parameter int DATA_W = imagem_pkg::DATA_W,
  parameter int LEN_W = imagem_pkg::LEN_W,
  parameter int FIFO_DEPTH = imagem_pkg::FIFO_DEPTH
)(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0] length,
  output logic busy,
  output logic done,
  imagem_stream_reader_if.master bus
);
  import imagem_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0] len, issued, received;
  logic [CW-1:0] outstanding, fifo_count;
  logic accept, push, pop, fifo_empty, credit, last_pop;
  logic [DATA_W+1:0] fifo_in, fifo_out;
  // Reads in flight plus buffered words never exceed the FIFO, so every return has a slot
  assign credit = int'(outstanding) + int'(fifo_count) < FIFO_DEPTH;
  assign bus.avm_read = state == RUN && issued < len && credit;
  assign bus.avm_address = state == RUN ? base + issued[ADDR_W-1:0] : '0;
  assign accept = bus.avm_read && !bus.avm_waitrequest;
  assign push = bus.avm_readdatavalid && state != IDLE;
  assign pop = bus.src_valid && bus.src_ready;
  assign fifo_in = {received == '0, received == len - LEN_W'(1), bus.avm_readdata};
  assign bus.src_valid = !fifo_empty;
  assign {bus.src_sop, bus.src_eop, bus.src_data} = fifo_empty ? '0 : fifo_out;
  assign last_pop = pop && fifo_out[DATA_W];
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start && length != '0 ? RUN : IDLE;
      RUN:     state_nx = accept && issued == len - LEN_W'(1) ? DRAIN : RUN;
      DRAIN:   state_nx = last_pop ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      base <= '0;
      len <= '0;
      issued <= '0;
      received <= '0;
      outstanding <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= (state == IDLE && start && length == '0) || (state == DRAIN && last_pop);
      if (state == IDLE && start) begin
        base <= base_addr;
        len <= length;
        issued <= '0;
        received <= '0;
      end else begin
        if (accept) issued <= issued + LEN_W'(1);
        if (push) received <= received + LEN_W'(1);
      end
      outstanding <= outstanding + CW'(accept) - CW'(push);
    end
  imagem_sync_fifo #(.W(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .wdata(fifo_in),
    .pop(pop),
    .rdata(fifo_out),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule
